// File: rtl/vscale_hasti_sram_slave.sv
// AHB-Lite (HASTI) subordinate backed by a word-organised memory array.
// Handles pipelined address/data phases, byte/half/word access, a fixed
// number of wait states per OKAY data phase and the two-cycle ERROR response.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | no data phase in progress; ready, OKAY
// ACC   | OKAY data phase; waits while counter != 0, completes at 0
// ERR1  | first ERROR cycle; not ready, hresp=1
// ERR2  | second ERROR cycle; ready, hresp=1
module vscale_hasti_sram_slave #(
    parameter int NWORDS      = 1024,
    parameter int WAIT_CYCLES = 0
) (
    input  logic        hclk,
    input  logic        hresetn,
    input  logic        hsel,
    input  logic [31:0] haddr,
    input  logic        hwrite,
    input  logic [2:0]  hsize,
    input  logic [2:0]  hburst,
    input  logic        hmastlock,
    input  logic [3:0]  hprot,
    input  logic [1:0]  htrans,
    input  logic [31:0] hwdata,
    input  logic        hready,
    output logic [31:0] hrdata,
    output logic        hreadyout,
    output logic        hresp
);

    localparam int         AW        = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ACC  = 2'd1;
    localparam logic [1:0] ST_ERR1 = 2'd2;
    localparam logic [1:0] ST_ERR2 = 2'd3;

    logic [1:0]    r_state;
    logic [1:0]    w_state_nxt;
    logic [3:0]    r_cnt;
    logic [3:0]    w_cnt_nxt;
    logic [31:0]   r_addr;
    logic          r_write;
    logic [2:0]    r_size;
    logic          r_err;
    logic          w_accept;
    logic          w_err;
    logic          w_commit;
    logic [3:0]    w_lanes;
    logic [AW-1:0] w_widx;
    logic          w_unused;
    logic [31:0]   r_mem [NWORDS];

    // Attributes the bus carries that this memory has no use for.
    assign w_unused = ^{hburst, hmastlock, hprot, htrans[0], r_addr[31:AW+2]};

    assign w_widx = r_addr[AW+1:2];

    // Classify the address phase currently on the bus as illegal or not.
    always_comb begin
        w_err = 1'b0;
        if (hsize > 3'd2)
            w_err = 1'b1;
        if ((hsize == 3'd1) && haddr[0])
            w_err = 1'b1;
        if ((hsize == 3'd2) && (haddr[1:0] != 2'b00))
            w_err = 1'b1;
        if ({2'b00, haddr[31:2]} >= 32'(NWORDS))
            w_err = 1'b1;
    end

    // Ready/response outputs follow directly from the data-phase state.
    always_comb begin
        hreadyout = 1'b1;
        hresp     = 1'b0;
        case (r_state)
            ST_ACC:  hreadyout = (r_cnt == 4'd0);
            ST_ERR1: begin
                hreadyout = 1'b0;
                hresp     = 1'b1;
            end
            ST_ERR2: hresp = 1'b1;
            default: ;
        endcase
    end

    // Our own ready gates acceptance so a stray hready during our waits is harmless.
    assign w_accept = hsel & hready & htrans[1] & hreadyout;

    // Next state and wait counter; a new transfer may overlap a completing one.
    always_comb begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = 4'd0;
        if (w_accept) begin
            w_state_nxt = w_err ? ST_ERR1 : ST_ACC;
            w_cnt_nxt   = w_err ? 4'd0 : WAIT_LOAD;
        end else begin
            case (r_state)
                ST_ACC: begin
                    if (r_cnt != 4'd0) begin
                        w_state_nxt = ST_ACC;
                        w_cnt_nxt   = r_cnt - 4'd1;
                    end
                end
                ST_ERR1: w_state_nxt = ST_ERR2;
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // State, counter and captured address-phase fields.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
            r_addr  <= 32'd0;
            r_write <= 1'b0;
            r_size  <= 3'd0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_accept) begin
                r_addr  <= haddr;
                r_write <= hwrite;
                r_size  <= hsize;
                r_err   <= w_err;
            end
        end
    end

    // Byte lanes touched by the captured transfer.
    always_comb begin
        case (r_size)
            3'd0:    w_lanes = 4'b0001 << r_addr[1:0];
            3'd1:    w_lanes = r_addr[1] ? 4'b1100 : 4'b0011;
            default: w_lanes = 4'b1111;
        endcase
    end

    // Writes land only on the completing edge of a clean data phase.
    assign w_commit = (r_state == ST_ACC) && (r_cnt == 4'd0) && r_write && !r_err;

    // Array update; contents survive reset.
    always_ff @(posedge hclk) begin
        if (w_commit) begin
            for (int i = 0; i < 4; i++) begin
                if (w_lanes[i])
                    r_mem[w_widx][8*i +: 8] <= hwdata[8*i +: 8];
            end
        end
    end

    // Whole word is returned for reads; the master picks its lanes.
    always_comb begin
        hrdata = 32'd0;
        if ((r_state == ST_ACC) && !r_write)
            hrdata = r_mem[w_widx];
    end

endmodule

// File: doc/vscale_hasti_sram_slave.md
# vscale_hasti_sram_slave

AHB-Lite (HASTI) subordinate that answers the transfers issued by the core's imem/dmem HASTI bridges from an internal word-organised memory array. It decodes address/data-phase pipelined transfers, performs byte/halfword/word reads and writes, inserts a programmable number of wait states, and returns the two-cycle ERROR response for illegal accesses. It sits on the bus side of the bridges, in the test harness or in an on-chip memory subsystem.

## Interface
- NWORDS, 1024: number of 32-bit words in the array; valid byte addresses are 0 to 4*NWORDS-1.
- WAIT_CYCLES, 0: wait states inserted in every OKAY data phase (0..15).

Ports:
- hclk  in  1  bus clock; the only clock.
- hresetn  in  1  reset, asynchronous, active-low.
- hsel  in  1  slave select.
- haddr  in  32  address-phase address.
- hwrite  in  1  1 = write.
- hsize  in  3  transfer size: 0 = byte, 1 = half, 2 = word.
- hburst  in  3  accepted, ignored (every beat treated independently).
- hmastlock  in  1  ignored.
- hprot  in  4  ignored.
- htrans  in  2  IDLE = 0, BUSY = 1, NONSEQ = 2, SEQ = 3.
- hwdata  in  32  write data, valid in the data phase.
- hready  in  1  bus-level ready; qualifies the address phase.
- hrdata  out  32  read data.
- hreadyout  out  1  this slave's ready.
- hresp  out  1  0 = OKAY, 1 = ERROR.

## Operation
- Address phase is accepted on a rising edge when hsel & hready & htrans[1]. On acceptance, register the address, hwrite and hsize, plus an error flag.
- The transfer is an error if any of these holds: hsize > 2; the access is misaligned (half with haddr[0]=1, word with haddr[1:0]≠0); or haddr[31:2] ≥ NWORDS.
- IDLE/BUSY transfers, or hsel low: no access; the next cycle is a zero-wait OKAY.
- FSM states:
  - IDLE: hreadyout=1, hresp=0.
  - ACC: OKAY data phase.
    - Counter loads WAIT_CYCLES; hreadyout=0 while counter≠0, decrementing each cycle.
    - With counter=0: hreadyout=1, the transfer completes and, for a write, commits at that edge.
  - ERR1: hreadyout=0, hresp=1.
  - ERR2: hreadyout=1, hresp=1.
- Transitions:
  - A new transfer can be accepted in the completing cycle of ACC or ERR2, or in IDLE (pipelined back-to-back transfers). It goes to ACC if clean, ERR1 if erroneous.
  - Otherwise the FSM returns to IDLE.
- Write lane enables:
  - Byte: lane addr[1:0].
  - Half: lanes {addr[1],0} and {addr[1],1}.
  - Word: all four.
  - Only enabled lanes of mem[addr[31:2]] are updated from the same hwdata lanes. An ERROR transfer never writes.
- Read: during an ACC read, hrdata = mem[addr_q[31:2]] (full word, all lanes; the master extracts). hrdata = 0 in every other cycle.
- Memory array contents are not reset.

## Timing
- Reset (hresetn low, asynchronous): state IDLE, hreadyout=1, hresp=0, hrdata=0, counter=0, registered phase fields cleared. Reset in mid-transfer aborts it; a pending write is discarded.
- OKAY latency: data phase lasts WAIT_CYCLES+1 cycles. With WAIT_CYCLES=0, back-to-back transfers sustain one per cycle.
- ERROR is always exactly 2 cycles: ERR1 then ERR2, independent of WAIT_CYCLES.
- Address phase is ignored while hready=0, including this slave's own wait and ERR1 cycles.
- Read-after-write:
  - A read whose address phase overlaps the write's completing data phase returns the new data. The write commits at that edge, and the read samples the array in the following cycle(s).
- Writes sample hwdata only on the completing edge (hreadyout=1). Values during wait states are don't-care.

## Test plan
1. WAIT_CYCLES=0: NONSEQ word write 0xDEADBEEF @0x10, then read @0x10 back-to-back -> hreadyout stays 1; the read data phase shows hrdata=0xDEADBEEF, hresp=0.
2. Byte write 0xAA@0x13 and half write 0x1234@0x10 into a word initialised to 0 -> word read @0x10 returns 0xAA001234.
3. WAIT_CYCLES=3: word read -> hreadyout low for exactly 3 cycles, then high with valid hrdata; hwdata changing during the waits of a write does not corrupt the commit.
4. Errors, each expected to give hreadyout 0→1 with hresp=1 for two cycles and the memory unchanged on a readback:
   - Word write @0x2 (misaligned).
   - Access @4*NWORDS (out of range).
   - hsize=3.
5. IDLE, BUSY, and hsel=0 with htrans=NONSEQ -> no array change, hreadyout=1, hresp=0; a NONSEQ issued while hready=0 is ignored.
6. Assert hresetn low in the 2nd wait cycle of a write -> outputs at reset values immediately; the target word retains its old value; the next transfer after release behaves normally.
